// File: rtl/arb_pkg.sv
// Shared types, default sizing and helpers for the round-robin arbiter.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int ARB_N        = 4;
   localparam int ARB_MAX_HOLD = 8;
   localparam int ARB_CNT_W    = 8;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_4_chk.sv
// Invariant checker for the arbiter outputs; attach alongside an rr_arbiter_4 instance.
module rr_arbiter_4_chk
   import arb_pkg::*;
#(
   parameter int N     = ARB_N,
   parameter int IDX_W = idx_width(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     gnt,
   input  logic [IDX_W-1:0] gnt_idx,
   input  logic             gnt_valid
);

   a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

   a_valid : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));

   a_idx : assert property (@(posedge clk) disable iff (!rst_n)
      gnt_valid |-> (gnt == ({{(N-1){1'b0}}, 1'b1} << gnt_idx)));

endmodule

// File: rtl/rr_pick.sv
// Circular priority encoder: first set bit of vec scanning from start upward,
// wrapping modulo N. found is low when vec is all zeros.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N     = ARB_N,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     vec,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [N-1:0]   mask_s;
   logic [2*N-1:0] dbl_s;

   // Thermometer mask selecting the positions at or above the start pointer.
   always_comb begin
      mask_s = '0;
      for (int i = 0; i < N; i++) begin
         mask_s[i] = (i >= int'(start));
      end
   end

   // Low half holds only candidates at/after start, high half the wrapped-around set,
   // so a plain lowest-bit-wins encoder over the doubled vector yields the circular winner.
   assign dbl_s = {vec, vec & mask_s};

   // Fixed-priority encoder over the doubled vector; position folds back modulo N.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 2*N-1; i >= 0; i--) begin
         idx   = dbl_s[i] ? IDX_W'(i) : idx;
         found = found | dbl_s[i];
      end
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter with grant hold and timeout-forced rotation, sharing one
// downstream configuration port among N requesters.
module rr_arbiter_4
   import arb_pkg::*;
#(
   parameter int N        = ARB_N,
   parameter int IDX_W    = idx_width(N),
   parameter int MAX_HOLD = ARB_MAX_HOLD,
   parameter int CNT_W    = ARB_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt
);

   localparam logic             TIMEOUT_EN = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST  = (MAX_HOLD != 0) ? CNT_W'(MAX_HOLD - 1) : '0;
   localparam logic [CNT_W-1:0] HOLD_SAT   = '1;

   arb_state_e       state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             valid_q, valid_d;
   logic             preempt_q, preempt_d;

   logic [N-1:0]     others_s;
   logic [IDX_W-1:0] req_idx_s, oth_idx_s;
   logic             req_found_s, oth_found_s;
   logic             holding_s, timeout_s;

   function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
      return {{(N-1){1'b0}}, 1'b1} << i;
   endfunction

   assign others_s  = req & ~onehot(idx_q);
   assign holding_s = req[idx_q];
   assign timeout_s = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);

   rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick_req (
      .vec   (req),
      .start (ptr_q),
      .idx   (req_idx_s),
      .found (req_found_s)
   );

   rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick_oth (
      .vec   (others_s),
      .start (ptr_q),
      .idx   (oth_idx_s),
      .found (oth_found_s)
   );

   // Next-state, grant and hold-counter logic.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      idx_d      = idx_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      preempt_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_found_s) begin
               state_d    = GRANT;
               gnt_d      = onehot(req_idx_s);
               idx_d      = req_idx_s;
               ptr_d      = req_idx_s + IDX_W'(1);
               hold_cnt_d = '0;
            end else begin
               state_d    = IDLE;
            end
         end
         GRANT: begin
            if (!holding_s) begin
               // A release wins over a coincident timeout, so no preempt here.
               if (oth_found_s) begin
                  gnt_d      = onehot(oth_idx_s);
                  idx_d      = oth_idx_s;
                  ptr_d      = oth_idx_s + IDX_W'(1);
                  hold_cnt_d = '0;
               end else begin
                  state_d    = IDLE;
                  gnt_d      = '0;
                  idx_d      = '0;
                  hold_cnt_d = '0;
               end
            end else if (timeout_s) begin
               if (oth_found_s) begin
                  gnt_d      = onehot(oth_idx_s);
                  idx_d      = oth_idx_s;
                  ptr_d      = oth_idx_s + IDX_W'(1);
                  hold_cnt_d = '0;
                  preempt_d  = 1'b1;
               end else begin
                  // Park on the last count so the timeout re-fires as soon as someone asks.
                  hold_cnt_d = HOLD_LAST;
               end
            end else begin
               hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d    = IDLE;
            gnt_d      = '0;
            idx_d      = '0;
            hold_cnt_d = '0;
         end
      endcase

      valid_d = |gnt_d;
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         idx_q      <= '0;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         valid_q    <= 1'b0;
         preempt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         idx_q      <= idx_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         valid_q    <= valid_d;
         preempt_q  <= preempt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;
   assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 (MAX_HOLD=4): reset, rotation, timeout,
// lone requester, pointer wrap and asynchronous reset mid-grant.
module tb_rr_arbiter_4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;

   int n_checks = 0;
   int n_fail   = 0;

   rr_arbiter_4 #(.N(4), .MAX_HOLD(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   rr_arbiter_4_chk #(.N(4)) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      req   = 4'b0000;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int order [5];
      int prev;
      order = '{0, 1, 2, 3, 0};

      // Reset state
      req   = 4'b0000;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_gnt",     32'(gnt),       32'h0);
      check_eq("rst_idx",     32'(gnt_idx),   32'h0);
      check_eq("rst_valid",   32'(gnt_valid), 32'h0);
      check_eq("rst_preempt", 32'(preempt),   32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request, one-cycle latency, then release to idle
      req = 4'b0100;
      tick();
      check_eq("single_gnt",   32'(gnt),       32'h4);
      check_eq("single_idx",   32'(gnt_idx),   32'd2);
      check_eq("single_valid", 32'(gnt_valid), 32'h1);
      req = 4'b0000;
      tick();
      check_eq("idle_gnt",   32'(gnt),       32'h0);
      check_eq("idle_valid", 32'(gnt_valid), 32'h0);

      // Round robin: each winner holds 3 cycles then drops, the previous dropper re-raises
      reset_dut();
      req  = 4'b1111;
      prev = -1;
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rr_gnt",     32'(gnt),     32'(1) << order[k]);
            check_eq("rr_idx",     32'(gnt_idx), 32'(order[k]));
            check_eq("rr_preempt", 32'(preempt), 32'h0);
         end
         req[order[k]] = 1'b0;
         if (prev >= 0) req[prev] = 1'b1;
         prev = order[k];
      end
      req = 4'b0000;
      tick();
      check_eq("rr_end_gnt", 32'(gnt), 32'h0);

      // Timeout: 0 held 4 cycles, preempted by 1 for 4 cycles, then back to 0
      reset_dut();
      req = 4'b0011;
      for (int c = 0; c < 4; c++) begin
         tick();
         check_eq("to_gnt0",  32'(gnt),     32'h1);
         check_eq("to_pre0",  32'(preempt), 32'h0);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         check_eq("to_gnt1", 32'(gnt),     32'h2);
         check_eq("to_pre1", 32'(preempt), (c == 0) ? 32'h1 : 32'h0);
      end
      tick();
      check_eq("to_back_gnt", 32'(gnt),     32'h1);
      check_eq("to_back_pre", 32'(preempt), 32'h1);
      tick();
      check_eq("to_back_pre_clr", 32'(preempt), 32'h0);

      // Lone requester keeps the grant past the timeout, then is preempted at once
      reset_dut();
      req = 4'b1000;
      for (int c = 0; c < 20; c++) begin
         tick();
         check_eq("lone_gnt", 32'(gnt),     32'h8);
         check_eq("lone_pre", 32'(preempt), 32'h0);
      end
      req = 4'b1010;
      tick();
      check_eq("lone_switch_gnt", 32'(gnt),     32'h2);
      check_eq("lone_switch_pre", 32'(preempt), 32'h1);

      // Pointer wrap: grant 3, release with only 0 waiting, then ptr must be 1
      reset_dut();
      req = 4'b1000;
      tick();
      check_eq("wrap_gnt3", 32'(gnt), 32'h8);
      req = 4'b0001;
      tick();
      check_eq("wrap_gnt0", 32'(gnt),     32'h1);
      check_eq("wrap_pre",  32'(preempt), 32'h0);
      req = 4'b0000;
      tick();
      check_eq("wrap_idle", 32'(gnt), 32'h0);
      req = 4'b1111;
      tick();
      check_eq("wrap_ptr_gnt", 32'(gnt),     32'h2);
      check_eq("wrap_ptr_idx", 32'(gnt_idx), 32'd1);

      // Asynchronous reset mid-grant
      reset_dut();
      req = 4'b0100;
      tick();
      check_eq("ar_gnt_before", 32'(gnt), 32'h4);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("ar_gnt_async",   32'(gnt),       32'h0);
      check_eq("ar_valid_async", 32'(gnt_valid), 32'h0);
      check_eq("ar_idx_async",   32'(gnt_idx),   32'h0);
      req = 4'b1111;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_eq("ar_first_gnt", 32'(gnt),     32'h1);
      check_eq("ar_first_idx", 32'(gnt_idx), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one downstream resource (a Benes switch-stage configuration port) among N requesters.
- Built around a circular priority encoder: the 4-input priority encoder with a rotating start pointer.
- Issues a registered one-hot grant plus an encoded index.
- Holds the grant while the winner keeps requesting. Pre-empts the winner after MAX_HOLD cycles if others are waiting.

Parameters:
- N, 4, number of requesters (power of two, 2..16).
- IDX_W, $clog2(N), width of the encoded grant index.
- MAX_HOLD, 8, maximum consecutive grant cycles before forced rotation; 0 disables the timeout.
- CNT_W, 8, hold-counter width; must satisfy MAX_HOLD < 2**CNT_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request vector; each requester holds its bit high until its transfer is done.
- gnt  out  N  one-hot grant, registered; all zeros when idle.
- gnt_idx  out  IDX_W  index of the granted requester; valid only while gnt_valid=1.
- gnt_valid  out  1  high when any grant is active; equals |gnt.
- preempt  out  1  one-cycle pulse in the cycle after a timeout-forced switch.

Behaviour:
- Reset (async assert, sync release): gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0.
- Winner function pick(vec, start):
  - Returns the first set bit of vec scanning start, start+1, ..., wrapping modulo N.
  - Returns none if vec=0.
- IDLE:
  - If req!=0, go to GRANT at the next edge with idx=pick(req, ptr).
  - On that edge: gnt=1<<idx, ptr<=(idx+1) mod N, hold_cnt<=0.
  - Latency from req to gnt is one clock.
- GRANT, req[idx]=1, no timeout:
  - Hold the grant; hold_cnt increments, saturating at 2**CNT_W-1.
- GRANT, req[idx]=0 (release):
  - Let o = req with bit idx cleared.
  - If o!=0: switch at the next edge to pick(o, ptr), with no idle bubble. Update ptr and reset hold_cnt.
  - Else go to IDLE with gnt=0.
- GRANT, timeout (MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, req[idx]=1):
  - If o!=0: switch to pick(o, ptr) at the next edge and pulse preempt=1 for that cycle.
  - If o==0: keep the grant. hold_cnt saturates and the timeout re-checks every cycle until another request appears.
- Simultaneous release and timeout: treat as a release; preempt=0.
- A grant is never given to a requester whose req bit is 0 at the sampling edge.
- Reset mid-grant: outputs clear immediately (asynchronously). The first arbitration after reset starts from ptr=0.
- Invariants:
  - gnt always has 0 or 1 bits set.
  - gnt_valid==|gnt.
  - When gnt_valid=1, gnt==1<<gnt_idx.
- Fairness: with all N requesting continuously and MAX_HOLD=M, grants rotate 0,1,...,N-1,0,... with M cycles each.

Decomposition:
- Package arb_pkg holds:
  - The state enum {IDLE, GRANT}.
  - Default constants for N, MAX_HOLD and CNT_W.
  - An index-width function.
- One sub-module, rr_pick: a combinational circular priority encoder.
  - Inputs: vec[N], start[IDX_W].
  - Outputs: idx[IDX_W], found.
  - Implementation: mask-and-double-vector, reusing the fixed-priority encoder style.

Test Plan:
- Reset then single request: req=0100 → gnt=0100, gnt_idx=2 one cycle later. Drop req → gnt=0000 next cycle.
- Round-robin with pulsed requests:
  - Stimulus: req=1111, each winner drops its bit after 3 cycles.
  - Required: grant order 0,1,2,3,0, each held 3 cycles, no idle cycles between them, preempt never asserted.
- Timeout with MAX_HOLD=4:
  - Stimulus: req=0011 held.
  - Required: gnt=0001 for 4 cycles, then 0010 with preempt=1 for one cycle, then 0001 after 4 more cycles.
- Lone requester, MAX_HOLD=4:
  - Stimulus: req=1000 held for 20 cycles.
  - Required: gnt=1000 throughout, preempt=0 throughout.
  - Then assert req[1]: gnt=0010 at the next edge, with preempt=1.
- Pointer wrap: grant idx 3, release while req=0001 → gnt=0001 next cycle, ptr wraps to 1.
- Async reset mid-grant:
  - Stimulus: assert rst_n=0 between clock edges while gnt=0100.
  - Required: gnt=0 immediately. After release with req=1111, the first grant is idx 0.
